ecc_sed_encoder_pipe: RTL and testbench

- Parametrised, pipelined single-error-detect (SED) parity encoder. It is the next-generation replacement for the fixed 12-bit combinational SED encoder.
- Appends NUM_GROUPS interleaved parity bits to a DATA_WIDTH data word.
- Parity polarity (even/odd) is selectable per word.
- Uses a registered valid/ready handshake with a 2-entry skid buffer, so it runs at full throughput under backpressure.
- Sits between the datapath source and the storage/link write port.

---
 rtl/ecc_sed_encoder_pipe.sv | 144 ++++++++++++++
 tb/tb_ecc_sed_encoder_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_sed_encoder_pipe.sv
// rtl/ecc_sed_encoder_pipe.sv - pipelined interleaved-parity SED encoder with 2-entry skid buffer
// Optional error injection port set enabled by macro ECC_SED_ERR_INJ_EN.
module ecc_sed_encoder_pipe #(
    parameter int DATA_WIDTH  = 12,
    parameter int NUM_GROUPS  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             data_valid,
    output logic                             data_ready,
    input  logic [DATA_WIDTH-1:0]            data,
    input  logic                             parity_odd,
    output logic                             enc_valid,
    input  logic                             enc_ready,
    output logic [DATA_WIDTH+NUM_GROUPS-1:0] enc_codeword,
    output logic [COUNT_WIDTH-1:0]           enc_count
`ifdef ECC_SED_ERR_INJ_EN
    ,
    input  logic                             err_inject,
    output logic [COUNT_WIDTH-1:0]           inj_count
`endif
);

    localparam int CW_W = DATA_WIDTH + NUM_GROUPS;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW_W-1:0]        out_q, out_d;
    logic [CW_W-1:0]        skid_q, skid_d;
    logic                   ready_q, ready_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [CW_W-1:0]        cw_in;
    logic                   accept;
    logic                   xfer;

    function automatic logic [NUM_GROUPS-1:0] calc_parity(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  odd
    );
        logic [NUM_GROUPS-1:0] p;
        p = {NUM_GROUPS{odd}};
        for (int g = 0; g < NUM_GROUPS; g++) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if ((i % NUM_GROUPS) == g) begin
                    p[g] = p[g] ^ d[i];
                end
            end
        end
        return p;
    endfunction

`ifdef ECC_SED_ERR_INJ_EN
    logic [COUNT_WIDTH-1:0] inj_q, inj_d;

    // Injection flips the lowest parity bit so a downstream checker sees a single-bit error.
    always_comb begin
        cw_in = {calc_parity(data, parity_odd), data};
        cw_in[DATA_WIDTH] = cw_in[DATA_WIDTH] ^ err_inject;
        inj_d = inj_q;
        if (accept && err_inject && (inj_q != {COUNT_WIDTH{1'b1}})) begin
            inj_d = inj_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_q <= '0;
        end else begin
            inj_q <= inj_d;
        end
    end

    assign inj_count = inj_q;
`else
    assign cw_in = {calc_parity(data, parity_odd), data};
`endif

    assign accept = data_valid & ready_q;
    assign xfer   = (state_q != ST_EMPTY) & enc_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = cw_in;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    out_d = cw_in;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = cw_in;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        ready_d = (state_d != ST_TWO);
        if (xfer && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign data_ready   = ready_q;
    assign enc_valid    = (state_q != ST_EMPTY);
    assign enc_codeword = out_q;
    assign enc_count    = count_q;

endmodule

// File: tb/tb_ecc_sed_encoder_pipe.sv
// tb/tb_ecc_sed_encoder_pipe.sv - scoreboard bench for ecc_sed_encoder_pipe
// Three instances share stimulus: 1 group, 2 groups, and a 4-bit counter.
module tb_ecc_sed_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_valid = 1'b0;
    logic        parity_odd = 1'b0;
    logic        enc_ready = 1'b1;
    logic        err_inject = 1'b0;
    logic [11:0] data = '0;

    logic        rdy1, rdy2, rdy4;
    logic        v1, v2, v4;
    logic [12:0] cw1, cw4;
    logic [13:0] cw2;
    logic [15:0] cnt1, cnt2;
    logic [3:0]  cnt4;
`ifdef ECC_SED_ERR_INJ_EN
    logic [15:0] inj1, inj2;
    logic [3:0]  inj4;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [12:0] e1;
        logic [13:0] e2;
    } exp_t;

    exp_t sbq[$];
    int   mc16 = 0;
    int   mc4  = 0;
    int   mi16 = 0;
    int   mi4  = 0;

    always #5 clk = ~clk;

    ecc_sed_encoder_pipe #(.DATA_WIDTH(12), .NUM_GROUPS(1), .COUNT_WIDTH(16)) u_g1 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy1), .data(data),
        .parity_odd(parity_odd), .enc_valid(v1), .enc_ready(enc_ready),
        .enc_codeword(cw1), .enc_count(cnt1)
`ifdef ECC_SED_ERR_INJ_EN
        , .err_inject(err_inject), .inj_count(inj1)
`endif
    );

    ecc_sed_encoder_pipe #(.DATA_WIDTH(12), .NUM_GROUPS(2), .COUNT_WIDTH(16)) u_g2 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy2), .data(data),
        .parity_odd(parity_odd), .enc_valid(v2), .enc_ready(enc_ready),
        .enc_codeword(cw2), .enc_count(cnt2)
`ifdef ECC_SED_ERR_INJ_EN
        , .err_inject(err_inject), .inj_count(inj2)
`endif
    );

    ecc_sed_encoder_pipe #(.DATA_WIDTH(12), .NUM_GROUPS(1), .COUNT_WIDTH(4)) u_c4 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy4), .data(data),
        .parity_odd(parity_odd), .enc_valid(v4), .enc_ready(enc_ready),
        .enc_codeword(cw4), .enc_count(cnt4)
`ifdef ECC_SED_ERR_INJ_EN
        , .err_inject(err_inject), .inj_count(inj4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Group masks: 0x555 selects even bit positions, 0xAAA odd positions.
    function automatic exp_t model(input logic [11:0] d, input logic odd, input logic inj);
        exp_t e;
        e.e1 = {(^d) ^ odd ^ inj, d};
        e.e2 = {(^(d & 12'hAAA)) ^ odd, (^(d & 12'h555)) ^ odd ^ inj, d};
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        check("cnt_g1", 32'(cnt1), 32'(mc16));
        check("cnt_g2", 32'(cnt2), 32'(mc16));
        check("cnt_c4", 32'(cnt4), 32'(mc4));
`ifdef ECC_SED_ERR_INJ_EN
        check("inj_g1", 32'(inj1), 32'(mi16));
        check("inj_c4", 32'(inj4), 32'(mi4));
`endif
        if (rst) begin
            sbq.delete();
            mc16 = 0; mc4 = 0; mi16 = 0; mi4 = 0;
        end else begin
            check("valid_lockstep", 32'({v2, v4}), 32'({v1, v1}));
            if (v1 && enc_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    check("cw_g1", 32'(cw1), 32'(e.e1));
                    check("cw_g2", 32'(cw2), 32'(e.e2));
                    check("cw_c4", 32'(cw4), 32'(e.e1));
                    if (mc16 < 65535) mc16++;
                    if (mc4 < 15) mc4++;
                end
            end
            if (data_valid && rdy1) begin
                sbq.push_back(model(data, parity_odd, err_inject));
                if (err_inject) begin
                    if (mi16 < 65535) mi16++;
                    if (mi4 < 15) mi4++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [11:0] d, input logic odd, input logic inj,
                             input logic [12:0] e1, input logic [13:0] e2);
        data = d; parity_odd = odd; err_inject = inj; data_valid = 1'b1;
        step();
        data_valid = 1'b0; err_inject = 1'b0;
        check("latency_valid", 32'(v1), 32'd1);
        check("direct_cw_g1", 32'(cw1), 32'(e1));
        check("direct_cw_g2", 32'(cw2), 32'(e2));
        step();
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            data = 12'($urandom); parity_odd = 1'($urandom); data_valid = 1'b1;
            step();
            check("stream_ready", 32'(rdy1), 32'd1);
            check("stream_valid", 32'(v1), 32'd1);
        end
        data_valid = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_cw", 32'(cw1), 32'd0);
        check("rst_cnt", 32'(cnt1), 32'd0);
        rst = 1'b0;
        enc_ready = 1'b1;

        send_word(12'h001, 1'b0, 1'b0, 13'h1001, 14'h1001);
        send_word(12'h003, 1'b0, 1'b0, 13'h0003, 14'h3003);
        send_word(12'h000, 1'b1, 1'b0, 13'h1000, 14'h3000);
        send_word(12'h002, 1'b0, 1'b0, 13'h1002, 14'h2002);
        send_word(12'hFFF, 1'b0, 1'b0, 13'h0FFF, 14'h0FFF);
        check("basic_cnt", 32'(cnt1), 32'd5);
        check("basic_empty", 32'(v1), 32'd0);

        pulse_reset();
        enc_ready = 1'b0;
        data = 12'h010; parity_odd = 1'b0; data_valid = 1'b1;
        step();
        check("bp_ready_one", 32'(rdy1), 32'd1);
        data = 12'h020;
        step();
        check("bp_ready_two", 32'(rdy1), 32'd0);
        data = 12'h030;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_ready", 32'(rdy1), 32'd0);
            check("bp_hold_cw", 32'(cw1), 32'h1010);
        end
        enc_ready = 1'b1;
        step();
        check("bp_second", 32'(cw1), 32'h1020);
        check("bp_ready_back", 32'(rdy1), 32'd1);
        step();
        check("bp_third", 32'(cw1), 32'h0030);
        data_valid = 1'b0;
        step();
        check("bp_cnt", 32'(cnt1), 32'd3);
        check("bp_empty", 32'(v1), 32'd0);

        pulse_reset();
        stream(8);
        check("stream_cnt", 32'(cnt1), 32'd8);

        pulse_reset();
        stream(5);
        enc_ready = 1'b0;
        data = 12'h0A5; data_valid = 1'b1;
        step();
        data = 12'h05A;
        step();
        data_valid = 1'b0;
        check("mid_two_ready", 32'(rdy1), 32'd0);
        check("mid_two_cnt", 32'(cnt1), 32'd5);
        pulse_reset();
        check("mid_rst_valid", 32'(v1), 32'd0);
        check("mid_rst_cnt", 32'(cnt1), 32'd0);
        check("mid_rst_ready", 32'(rdy1), 32'd1);
        enc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_emit", 32'(v1), 32'd0);
        end

        stream(20);
        check("sat_cnt4", 32'(cnt4), 32'd15);
        check("sat_cnt16", 32'(cnt1), 32'd20);

`ifdef ECC_SED_ERR_INJ_EN
        pulse_reset();
        send_word(12'h001, 1'b0, 1'b1, 13'h0001, 14'h0001);
        check("inj_count", 32'(inj1), 32'd1);
`endif

        repeat (3) step();
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
